// File: rtl/vga_timing.sv
// vga_timing: VGA raster counters with registered sync, blanking and frame/line strobes.
//
// Ports:
//   clk         pixel clock (25 MHz for the default 640x480 mode)
//   rst_n       asynchronous active-low reset
//   hcount      current pixel column, 0..H_TOTAL-1
//   vcount      current line, 0..V_TOTAL-1
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   video_on    high inside the visible H_ACTIVE x V_ACTIVE window
//   line_start  one-cycle pulse while hcount==0
//   frame_start one-cycle pulse while hcount==0 and vcount==0
//   frame_cnt   frames completed since reset
//
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the frame counter;
// without it frame_cnt is tied to zero and no counter register exists.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // Decode limits are 11 bits so a sync/active edge landing exactly on 1024 still compares correctly.
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;

    always_comb begin
        h_nxt = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
        v_nxt = (hcount != H_LAST) ? vcount : (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end

    // Outputs are decoded from the next counter values so they line up with the registered counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= !({1'b0, h_nxt} >= HS_BEG && {1'b0, h_nxt} < HS_END);
            vsync       <= !({1'b0, v_nxt} >= VS_BEG && {1'b0, v_nxt} < VS_END);
            video_on    <= {1'b0, h_nxt} < H_VIS && {1'b0, v_nxt} < V_VIS;
            line_start  <= h_nxt == 10'd0;
            frame_start <= h_nxt == 10'd0 && v_nxt == 10'd0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = '0;
`endif
endmodule
